// File: rtl/decoder_nto2n_scan.sv
// Registered N-to-2^N decoder with one-hot, thermometer and autonomous scan modes.
// All outputs come straight from flops, so select lines stay glitch-free.
module decoder_nto2n_scan #(
  parameter int SEL_W     = 3,
  parameter int SCAN_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  load,
  output logic [2**SEL_W-1:0]   y,
  output logic                  y_valid,
  output logic [SEL_W-1:0]      scan_idx,
  output logic                  scan_wrap
);

  localparam int OUT_W  = 2**SEL_W;
  localparam int HOLD_W = (SCAN_HOLD > 1) ? $clog2(SCAN_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SCAN_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STATIC = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t             state;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [OUT_W-1:0]   dec;
  logic [SEL_W-1:0]   nxt_idx;
  logic [OUT_W-1:0]   nxt_onehot;

  // mode[0] selects thermometer (01) versus one-hot (00) for static loads
  always_comb begin
    dec = '0;
    if (mode[0]) begin
      for (int unsigned i = 0; i < OUT_W; i++)
        dec[i] = (i <= 32'(sel));
    end else begin
      dec[sel] = 1'b1;
    end
  end

  always_comb begin
    nxt_idx    = scan_idx + SEL_W'(1);
    nxt_onehot = OUT_W'(1) << nxt_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      y         <= '0;
      y_valid   <= 1'b0;
      scan_idx  <= '0;
      scan_wrap <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      scan_wrap <= 1'b0;
      if (!enable || mode == 2'b11) begin
        state    <= IDLE;
        y        <= '0;
        y_valid  <= 1'b0;
        scan_idx <= '0;
        hold_cnt <= '0;
      end else if (mode == 2'b10) begin
        if (state != SCAN) begin
          state    <= SCAN;
          y        <= OUT_W'(1);
          y_valid  <= 1'b1;
          scan_idx <= '0;
          hold_cnt <= '0;
        end else if (hold_cnt == HOLD_LAST) begin
          hold_cnt  <= '0;
          scan_idx  <= nxt_idx;
          y         <= nxt_onehot;
          scan_wrap <= (scan_idx == '1);
        end else begin
          hold_cnt <= hold_cnt + HOLD_W'(1);
        end
      end else begin
        scan_idx <= '0;
        hold_cnt <= '0;
        if (load) begin
          state   <= STATIC;
          y       <= dec;
          y_valid <= 1'b1;
        end else if (state == SCAN) begin
          // leaving scan without a load freezes the last strobe pattern
          state   <= STATIC;
          y_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_decoder_nto2n_scan.sv
// Directed self-checking bench for decoder_nto2n_scan (SEL_W=3, dwell 4 and dwell 1).
module tb_decoder_nto2n_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [1:0] mode;
  logic [2:0] sel;
  logic       load;

  logic [7:0] y4, y1;
  logic       v4, v1;
  logic [2:0] idx4, idx1;
  logic       w4, w1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decoder_nto2n_scan #(.SEL_W(3), .SCAN_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .sel(sel), .load(load),
    .y(y4), .y_valid(v4), .scan_idx(idx4), .scan_wrap(w4)
  );

  decoder_nto2n_scan #(.SEL_W(3), .SCAN_HOLD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .sel(sel), .load(load),
    .y(y1), .y_valid(v1), .scan_idx(idx1), .scan_wrap(w1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; mode = 2'b00; sel = '0; load = 1'b0;
    #12;
    n_checks++;
    if ({y4, v4, idx4, w4} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_h4: got y=%h v=%b idx=%0d w=%b, want all zero", y4, v4, idx4, w4);
    end
    n_checks++;
    if ({y1, v1, idx1, w1} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_h1: got y=%h v=%b idx=%0d w=%b, want all zero", y1, v1, idx1, w1);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_onehot();
    logic [2:0] sels [3] = '{3'd5, 3'd0, 3'd7};
    logic [7:0] exps [3] = '{8'h20, 8'h01, 8'h80};
    enable = 1'b1; mode = 2'b00;
    for (int k = 0; k < 3; k++) begin
      sel = sels[k]; load = 1'b1;
      tick();
      n_checks++;
      if (y4 !== exps[k] || v4 !== 1'b1) begin
        n_fail++;
        $display("FAIL onehot_load sel=%0d: got y=%h v=%b, want y=%h v=1", sels[k], y4, v4, exps[k]);
      end
      load = 1'b0; sel = 3'd2;
      tick();
      n_checks++;
      if (y4 !== exps[k] || v4 !== 1'b1) begin
        n_fail++;
        $display("FAIL onehot_hold sel=%0d: got y=%h v=%b, want y=%h v=1", sels[k], y4, v4, exps[k]);
      end
    end
  endtask

  task automatic test_thermo();
    logic [2:0] sels [3] = '{3'd0, 3'd7, 3'd3};
    logic [7:0] exps [3] = '{8'h01, 8'hFF, 8'h0F};
    enable = 1'b1; mode = 2'b01;
    for (int k = 0; k < 3; k++) begin
      sel = sels[k]; load = 1'b1;
      tick();
      n_checks++;
      if (y4 !== exps[k] || v4 !== 1'b1) begin
        n_fail++;
        $display("FAIL thermo sel=%0d: got y=%h v=%b, want y=%h v=1", sels[k], y4, v4, exps[k]);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_scan_hold4();
    logic [7:0] ey;
    logic [2:0] ei;
    logic       ew;
    enable = 1'b1; mode = 2'b10; load = 1'b1; sel = 3'd6;
    tick();
    for (int k = 0; k < 34; k++) begin
      ei = 3'((k / 4) % 8);
      ey = 8'd1 << ei;
      ew = (k == 32);
      n_checks++;
      if (y4 !== ey || idx4 !== ei || w4 !== ew || v4 !== 1'b1) begin
        n_fail++;
        $display("FAIL scan_h4 k=%0d: got y=%h idx=%0d w=%b v=%b, want y=%h idx=%0d w=%b v=1",
                 k, y4, idx4, w4, v4, ey, ei, ew);
      end
      tick();
    end
  endtask

  task automatic test_scan_hold1();
    logic [7:0] ey;
    logic [2:0] ei;
    logic       ew;
    enable = 1'b0;
    tick();
    enable = 1'b1; mode = 2'b10;
    tick();
    for (int k = 0; k < 18; k++) begin
      ei = 3'(k % 8);
      ey = 8'd1 << ei;
      ew = (k > 0) && (k % 8 == 0);
      n_checks++;
      if (y1 !== ey || idx1 !== ei || w1 !== ew || v1 !== 1'b1) begin
        n_fail++;
        $display("FAIL scan_h1 k=%0d: got y=%h idx=%0d w=%b v=%b, want y=%h idx=%0d w=%b v=1",
                 k, y1, idx1, w1, v1, ey, ei, ew);
      end
      tick();
    end
  endtask

  task automatic test_priority();
    enable = 1'b1; mode = 2'b10;
    tick(); tick(); tick(); tick(); tick();
    enable = 1'b0; load = 1'b1; mode = 2'b00; sel = 3'd3;
    tick();
    n_checks++;
    if (y4 !== 8'h00 || v4 !== 1'b0 || idx4 !== 3'd0) begin
      n_fail++;
      $display("FAIL enable_off: got y=%h v=%b idx=%0d, want y=00 v=0 idx=0", y4, v4, idx4);
    end
    enable = 1'b1; mode = 2'b00; sel = 3'd4; load = 1'b1;
    tick();
    n_checks++;
    if (y4 !== 8'h10 || v4 !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reserved: got y=%h v=%b, want y=10 v=1", y4, v4);
    end
    mode = 2'b11;
    tick();
    n_checks++;
    if (y4 !== 8'h00 || v4 !== 1'b0) begin
      n_fail++;
      $display("FAIL reserved_mode: got y=%h v=%b, want y=00 v=0", y4, v4);
    end
    load = 1'b0;
  endtask

  task automatic test_mode_exit();
    enable = 1'b1; mode = 2'b10; load = 1'b0;
    tick();
    repeat (8) tick();
    n_checks++;
    if (y4 !== 8'h04 || idx4 !== 3'd2) begin
      n_fail++;
      $display("FAIL exit_pre: got y=%h idx=%0d, want y=04 idx=2", y4, idx4);
    end
    mode = 2'b00; sel = 3'd6;
    tick();
    n_checks++;
    if (y4 !== 8'h04 || v4 !== 1'b1 || idx4 !== 3'd0) begin
      n_fail++;
      $display("FAIL exit_hold: got y=%h v=%b idx=%0d, want y=04 v=1 idx=0", y4, v4, idx4);
    end
    tick();
    n_checks++;
    if (y4 !== 8'h04 || v4 !== 1'b1) begin
      n_fail++;
      $display("FAIL exit_hold2: got y=%h v=%b, want y=04 v=1", y4, v4);
    end
    load = 1'b1;
    tick();
    n_checks++;
    if (y4 !== 8'h40 || v4 !== 1'b1) begin
      n_fail++;
      $display("FAIL exit_load: got y=%h v=%b, want y=40 v=1", y4, v4);
    end
    load = 1'b0;
  endtask

  task automatic test_async_reset();
    enable = 1'b1; mode = 2'b10; load = 1'b0;
    tick();
    repeat (20) tick();
    n_checks++;
    if (idx4 !== 3'd5 || y4 !== 8'h20) begin
      n_fail++;
      $display("FAIL areset_pre: got y=%h idx=%0d, want y=20 idx=5", y4, idx4);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (y4 !== 8'h00 || v4 !== 1'b0 || idx4 !== 3'd0) begin
      n_fail++;
      $display("FAIL areset_mid: got y=%h v=%b idx=%0d, want y=00 v=0 idx=0", y4, v4, idx4);
    end
    tick();
    #2 rst_n = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (idx4 !== 3'(k / 4) || y4 !== (8'd1 << (k / 4)) || v4 !== 1'b1) begin
        n_fail++;
        $display("FAIL areset_reentry k=%0d: got y=%h idx=%0d v=%b, want idx=%0d", k, y4, idx4, v4, k / 4);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_onehot();
    test_thermo();
    test_scan_hold4();
    test_scan_hold1();
    test_priority();
    test_mode_exit();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder_nto2n_scan.md
Name: decoder_nto2n_scan

Overview:
- Registered, parametrised N-to-2^N decoder.
- Three output modes: one-hot, thermometer, and an autonomous scan mode that walks a one-hot bit across all outputs with a programmable dwell time.
- Drives select lines for LED/row strobes and bus-enable fans from a single binary index, with glitch-free registered outputs.

Parameters:
- SEL_W, 3, select width; output width OUT_W = 2**SEL_W (derived localparam); legal range 1..6.
- SCAN_HOLD, 4, cycles each output is held active in scan mode; legal range >=1; hold counter width is clog2(SCAN_HOLD) with a minimum of 1 bit.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  block enable; 0 forces IDLE.
- mode  input  2  00 one-hot, 01 thermometer, 10 scan, 11 reserved.
- sel  input  SEL_W  binary index for one-hot/thermometer.
- load  input  1  strobe; captures sel and mode into the output register.
- y  output  OUT_W  registered decoded output.
- y_valid  output  1  y holds a decoded value.
- scan_idx  output  SEL_W  index currently driven in scan mode; 0 outside scan.
- scan_wrap  output  1  one-cycle pulse when scan wraps from OUT_W-1 to 0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - y=0, y_valid=0, scan_idx=0, scan_wrap=0, hold counter=0, state=IDLE.
  - Release is synchronous to clk.
- States: IDLE, STATIC, SCAN. All outputs are registered, with 1-cycle latency from sampled inputs.
- Priority order each cycle: enable=0, then mode=11, then mode=10, then load.
- enable=0 (any state): next cycle state=IDLE, y=0, y_valid=0, scan_idx=0, hold counter=0, scan_wrap=0.
- mode=11 with enable=1: treated as enable=0 (IDLE, outputs cleared).
- IDLE/STATIC, mode 00 or 01, load=1: next cycle state=STATIC, y_valid=1.
  - mode 00: y = 1<<sel.
  - mode 01: y[i]=1 for all i<=sel (sel=0 gives ...0001; sel=OUT_W-1 gives all ones).
  - A load in STATIC overwrites y the same way (back-to-back loads allowed, one update per cycle).
- IDLE/STATIC, mode 00/01, load=0: y and y_valid hold.
- Entering SCAN (mode=10, enable=1, from IDLE or STATIC): next cycle y=...0001, scan_idx=0, hold counter=0, y_valid=1. load and sel are ignored while in SCAN.
- SCAN dwell:
  - Hold counter increments every cycle.
  - When the counter equals SCAN_HOLD-1, next cycle: scan_idx = scan_idx+1 mod OUT_W, y = 1<<new scan_idx, counter=0.
  - SCAN_HOLD=1: advances every cycle.
  - Each index is therefore visible for exactly SCAN_HOLD cycles.
- Wrap: scan_wrap=1 for exactly the first cycle y shows index 0 after index OUT_W-1. It is not asserted on initial scan entry.
- Leaving SCAN (mode becomes 00/01, enable=1):
  - load=0: state=STATIC, y holds last scan value, y_valid=1, scan_idx=0.
  - load=1: decode of sel applied next cycle.
- Re-entering SCAN always restarts at index 0.
- y is always one-hot, thermometer, or zero; never any other pattern.
- Reset asserted mid-scan: outputs clear immediately (asynchronous), without waiting for clk.

Test Plan:
- Reset and direct decode (SEL_W=3): reset, enable=1, mode=00, sel=5, load=1 for 1 cycle -> next edge y=8'b00100000, y_valid=1; y holds after load drops.
- Thermometer endpoints: mode=01, load sel=0 -> y=8'b00000001; load sel=7 -> y=8'hFF; load sel=3 -> y=8'b00001111.
- Scan, SCAN_HOLD=4:
  - mode=10 -> each one-hot value held exactly 4 cycles.
  - scan_idx steps 0..7.
  - After 32 cycles y=8'h01, scan_wrap high for 1 cycle only.
  - Repeat with SCAN_HOLD=1: new index every cycle, wrap every 8 cycles.
- Enable/reserved priority:
  - Mid-scan drive enable=0 with load=1 -> next cycle y=0, y_valid=0, scan_idx=0.
  - mode=11 with load=1 -> y=0, y_valid=0.
- Mode exit: scan at index 2, switch to mode=00 with load=0 -> y stays 8'b00000100, y_valid=1, scan_idx=0; next load sel=6 -> y=8'b01000000.
- Async reset mid-scan: assert rst_n=0 between clock edges at index 5 -> y=0, y_valid=0 before the next edge; after release, re-entry to scan starts at index 0.
